mont_mul_radix2: RTL and testbench

Iterative radix-2 Montgomery modular multiplier. Computes R = A·B·2^-K mod M, one bit of A per cycle, then applies a final conditional subtraction. It is the sequential stage that drives the team's cla_adder instances and consumes their sums. All adds and subtracts go through cla_adder; no behavioural "+" or "-" on datapath words.

---
 rtl/mont_mul_radix2.sv | 194 +++++++++++++++++++
 tb/tb_mont_mul_radix2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_radix2.sv
// Radix-2 Montgomery multiplier R = A*B*2^-K mod M, one multiplicand bit per cycle; K+2 cycles start to done.
// One operation in flight: start is only honoured while idle, never queued.
module cla_adder #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         gacc;
  logic         pacc;
  logic         base;
  logic         carry_unused;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups: each bit's carry comes straight from its group's incoming carry
  always_comb begin
    c    = '0;
    c[0] = cin;
    gacc = 1'b0;
    pacc = 1'b1;
    base = cin;
    for (int k = 0; k < W; k++) begin
      if (k % 4 == 0) begin
        gacc = 1'b0;
        pacc = 1'b1;
        base = c[k];
      end
      gacc     = g[k] | (p[k] & gacc);
      pacc     = p[k] & pacc;
      c[k + 1] = gacc | (pacc & base);
    end
  end

  assign sum          = p ^ c[W-1:0];
  assign carry_unused = c[W];

endmodule

module mont_mul_radix2 #(
  parameter int K = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic [K-1:0] M,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] R
);

  localparam int W  = K + 2;
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINAL
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [W-1:0]   s;
  logic [W-1:0]   s_n;
  logic [IW-1:0]  i;
  logic [IW-1:0]  i_n;
  logic [K-1:0]   ar;
  logic [K-1:0]   ar_n;
  logic [K-1:0]   br;
  logic [K-1:0]   br_n;
  logic [K-1:0]   mr;
  logic [K-1:0]   mr_n;
  logic [K-1:0]   r_n;
  logic           done_n;
  logic           busy_n;

  logic           a_i;
  logic           q;
  logic [W-1:0]   addend_b;
  logic [W-1:0]   addend_m;
  logic [W-1:0]   t1;
  logic [W-1:0]   t2;
  logic [W-1:0]   neg_m;
  logic [W-1:0]   d;
  logic           d_unused;

  assign a_i      = ar[i];
  assign q        = s[0] ^ (a_i & br[0]);
  assign addend_b = a_i ? {2'b00, br} : '0;
  assign addend_m = q ? {2'b00, mr} : '0;
  assign neg_m    = ~{2'b00, mr};

  cla_adder #(.W(W)) u_add_b (
    .a   (s),
    .b   (addend_b),
    .cin (1'b0),
    .sum (t1)
  );

  cla_adder #(.W(W)) u_add_m (
    .a   (t1),
    .b   (addend_m),
    .cin (1'b0),
    .sum (t2)
  );

  // S - M; the top bit is set exactly when S < M (borrow)
  cla_adder #(.W(W)) u_sub_m (
    .a   (s),
    .b   (neg_m),
    .cin (1'b1),
    .sum (d)
  );

  assign d_unused = d[K];

  always_comb begin
    state_n = state;
    s_n     = s;
    i_n     = i;
    ar_n    = ar;
    br_n    = br;
    mr_n    = mr;
    r_n     = R;
    done_n  = 1'b0;
    busy_n  = busy;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          ar_n    = A;
          br_n    = B;
          mr_n    = M;
          s_n     = '0;
          i_n     = '0;
          busy_n  = 1'b1;
          state_n = ITER;
        end
      end
      ITER: begin
        // T2 is even by choice of q, so the shift drops no information
        s_n = t2 >> 1;
        i_n = i + IW'(1);
        if (i == IW'(K - 1)) begin
          state_n = FINAL;
        end
      end
      FINAL: begin
        r_n     = d[W-1] ? s[K-1:0] : d[K-1:0];
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      i     <= '0;
      ar    <= '0;
      br    <= '0;
      mr    <= '0;
      R     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      i     <= i_n;
      ar    <= ar_n;
      br    <= br_n;
      mr    <= mr_n;
      R     <= r_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Bench for mont_mul_radix2: directed K=8 scenarios plus random K=32 operations against an arithmetic model.
module tb_mont_mul_radix2;

  logic        clk;
  logic        rst;
  logic        start8;
  logic [7:0]  a8, b8, m8;
  logic        busy8, done8;
  logic [7:0]  r8;
  logic        start32;
  logic [31:0] a32, b32, m32;
  logic        busy32, done32;
  logic [31:0] r32;

  int n_cmp;
  int n_err;

  mont_mul_radix2 #(.K(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .M     (m8),
    .busy  (busy8),
    .done  (done8),
    .R     (r8)
  );

  mont_mul_radix2 #(.K(32)) dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start32),
    .A     (a32),
    .B     (b32),
    .M     (m32),
    .busy  (busy32),
    .done  (done32),
    .R     (r32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A*B*2^-k mod m: reduce the product, then halve modulo m k times
  function automatic longint unsigned mont_ref(longint unsigned a, longint unsigned b,
                                               longint unsigned m, int k);
    longint unsigned x;
    x = (a * b) % m;
    for (int j = 0; j < k; j++) begin
      if (x[0]) x = (x + m) >> 1;
      else      x = x >> 1;
    end
    return x;
  endfunction

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    a8     = a;
    b8     = b;
    m8     = m;
    start8 = 1'b1;
  endtask

  // Samples on negedges; n counts cycles since the start was presented. Extra start pulses at ign1/ign2.
  task automatic wait8(input int n0, input int ign1, input int ign2,
                       output int lat, output int busy_bad);
    lat      = 99;
    busy_bad = 0;
    for (int n = n0; n <= 40; n++) begin
      @(negedge clk);
      if (n == ign1 || n == ign2) begin
        start8 = 1'b1;
        a8     = 8'd3;
        b8     = 8'd4;
        m8     = 8'd11;
      end else begin
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        m8     = 8'($urandom);
      end
      if (done8) begin
        lat = n;
        break;
      end
      if (!busy8) busy_bad++;
    end
  endtask

  initial begin
    int lat;
    int bb;
    int pulses;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [7:0] te [3];
    longint unsigned ra, rb, rm, exp32;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    m8      = '0;
    start32 = 1'b0;
    a32     = '0;
    b32     = '0;
    m32     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_r", r8, 0);
    check("reset_r32", r32, 0);
    rst = 1'b0;

    // Basic operation, latency and busy window
    @(negedge clk);
    launch8(8'd5, 8'd7, 8'd13);
    wait8(1, 0, 0, lat, bb);
    check("t1_latency", lat, 10);
    check("t1_busy_gaps", bb, 0);
    check("t1_busy_at_done", busy8, 0);
    check("t1_result", r8, 1);
    @(negedge clk);
    check("t1_single_done", done8, 0);
    check("t1_r_hold", r8, 1);

    ta[0] = 8'd1;  tb[0] = 8'd1;  te[0] = 8'd3;
    ta[1] = 8'd0;  tb[1] = 8'd12; te[1] = 8'd0;
    ta[2] = 8'd12; tb[2] = 8'd12; te[2] = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      launch8(ta[k], tb[k], 8'd13);
      wait8(1, 0, 0, lat, bb);
      check("t2_latency", lat, 10);
      check("t2_result", r8, te[k]);
    end

    @(negedge clk);
    launch8(8'd254, 8'd254, 8'd255);
    wait8(1, 0, 0, lat, bb);
    check("t3_latency", lat, 10);
    check("t3_result", r8, 1);

    // Starts during an operation are ignored; then chain a new start in the done cycle
    @(negedge clk);
    launch8(8'd12, 8'd11, 8'd13);
    wait8(1, 3, 5, lat, bb);
    check("t4_latency", lat, 10);
    check("t4_busy_gaps", bb, 0);
    check("t4_result", r8, 6);
    launch8(8'd9, 8'd10, 8'd13);
    @(negedge clk);
    start8 = 1'b0;
    check("t4_chain_busy", busy8, 1);
    check("t4_chain_r_hold", r8, 6);
    wait8(2, 0, 0, lat, bb);
    check("t4_chain_latency", lat, 10);
    check("t4_chain_result", r8, 10);

    // Reset in the middle of an operation
    @(negedge clk);
    launch8(8'd5, 8'd7, 8'd13);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy_in_reset", busy8, 0);
    check("t5_done_in_reset", done8, 0);
    check("t5_r_in_reset", r8, 0);
    rst    = 1'b0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    check("t5_no_activity", pulses, 0);
    check("t5_r_after", r8, 0);
    launch8(8'd12, 8'd12, 8'd13);
    wait8(1, 0, 0, lat, bb);
    check("t5_fresh_latency", lat, 10);
    check("t5_fresh_result", r8, 3);

    // Out-of-contract operands still finish on time with one pulse
    @(negedge clk);
    launch8(8'd200, 8'd77, 8'd12);
    wait8(1, 0, 0, lat, bb);
    check("ooc_latency", lat, 10);
    @(negedge clk);
    check("ooc_single_done", done8, 0);

    // Random K=32 operations
    for (int t = 0; t < 1000; t++) begin
      rm = longint'($urandom) | 64'd1;
      if (rm < 3) rm = 3;
      ra = longint'($urandom) % rm;
      rb = longint'($urandom) % rm;
      exp32 = mont_ref(ra, rb, rm, 32);
      @(negedge clk);
      a32     = ra[31:0];
      b32     = rb[31:0];
      m32     = rm[31:0];
      start32 = 1'b1;
      lat     = 99;
      for (int n = 1; n <= 60; n++) begin
        @(negedge clk);
        start32 = 1'b0;
        a32     = $urandom;
        b32     = $urandom;
        m32     = $urandom;
        if (done32) begin
          lat = n;
          break;
        end
      end
      check("k32_latency", lat, 34);
      check("k32_result", r32, exp32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
